exp_log_encoder: RTL and testbench

Inverse of the exponential amplitude curve. Takes a 7-bit linear amplitude and returns the 5-bit curve index whose value best matches it, so measured or user-supplied levels can be fed back into the 5-bit envelope path. It runs a sequential successive-approximation search over the shared 32-entry curve, resolving one index bit per cycle. It sits between the amplitude source and the envelope/delay logic, on the same 10 MHz domain.

---
 rtl/exp_log_encoder_pkg.sv | 30 +++
 rtl/exp_curve_rom.sv | 17 +
 rtl/exp_log_encoder.sv | 152 +++++++++++++++
 tb/tb_exp_log_encoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/exp_log_encoder_pkg.sv
// exp_log_encoder_pkg
//   Shared definitions for the exponential amplitude curve and its inverse
//   encoder: index/amplitude widths, the 32-entry curve and the encoder FSM
//   state type. Forward and inverse paths both read CURVE from here.
//   Optional feature macro: EXP_LOG_ENCODER_ROUND_EN (adds ST_ROUND).
package exp_log_encoder_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned AMP_W  = 7;

  // Non-decreasing exponential amplitude curve, index 0..31.
  localparam logic [AMP_W-1:0] CURVE [32] = '{
    7'd0,   7'd0,   7'd0,   7'd1,   7'd2,   7'd3,   7'd4,   7'd6,
    7'd8,   7'd10,  7'd13,  7'd15,  7'd19,  7'd22,  7'd25,  7'd29,
    7'd33,  7'd38,  7'd42,  7'd47,  7'd52,  7'd58,  7'd63,  7'd69,
    7'd76,  7'd82,  7'd89,  7'd96,  7'd103, 7'd111, 7'd118, 7'd127
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
`ifdef EXP_LOG_ENCODER_ROUND_EN
    ST_DONE   = 2'd2,
    ST_ROUND  = 2'd3
`else
    ST_DONE   = 2'd2
`endif
  } state_e;

endpackage

// File: rtl/exp_curve_rom.sv
// exp_curve_rom
//   Combinational index -> amplitude lookup of the shared exponential curve.
//   Ports:
//     idx  in  CODE_W  curve index
//     val  out AMP_W   CURVE[idx]
module exp_curve_rom
  import exp_log_encoder_pkg::*;
(
  input  logic [CODE_W-1:0] idx,
  output logic [AMP_W-1:0]  val
);

  always_comb begin
    val = CURVE[idx];
  end

endmodule

// File: rtl/exp_log_encoder.sv
// exp_log_encoder
//   Inverse of the exponential amplitude curve: converts a 7-bit linear
//   amplitude into the 5-bit curve index whose value best matches it, using a
//   successive-approximation search that resolves one index bit per cycle.
//   Default result is the floor index (largest k with CURVE[k] <= in).
//   Optional macro EXP_LOG_ENCODER_ROUND_EN adds a rounding cycle that picks
//   k+1 when it is strictly closer (ties stay at k).
//   Ports:
//     MHz10     in   1  system clock, rising edge
//     nrst      in   1  asynchronous active-low reset
//     en        in   1  enable; low aborts a search and blocks starts
//     in        in   7  linear amplitude, sampled on the start edge
//     ready     in   1  start strobe, honoured only when enabled and idle
//     code_out  out  5  resulting curve index, held until the next result
//     valid     out  1  one-cycle pulse when code_out updates
//     busy      out  1  high while searching (and rounding)
module exp_log_encoder
  import exp_log_encoder_pkg::*;
(
  input  logic              MHz10,
  input  logic              nrst,
  input  logic              en,
  input  logic [AMP_W-1:0]  in,
  input  logic              ready,
  output logic [CODE_W-1:0] code_out,
  output logic              valid,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [AMP_W-1:0]    x_q, x_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [2:0]          bit_q, bit_d;
  logic [CODE_W-1:0]   code_out_q, code_out_d;
  logic                valid_q, valid_d;

  logic [CODE_W-1:0]   trial;
  logic [CODE_W-1:0]   rom_idx;
  logic [AMP_W-1:0]    c_lo;

  assign trial = code_q | (CODE_W'(1) << bit_q);

  // One lookup serves both the trial probe in SEARCH and C[k] in ROUND.
  exp_curve_rom u_rom_lo (
    .idx (rom_idx),
    .val (c_lo)
  );

`ifdef EXP_LOG_ENCODER_ROUND_EN
  logic [CODE_W-1:0]   code_inc;
  logic [AMP_W-1:0]    c_hi;
  logic [AMP_W:0]      diff_hi;
  logic [AMP_W:0]      diff_lo;

  assign code_inc = code_q + CODE_W'(1);

  exp_curve_rom u_rom_hi (
    .idx (code_inc),
    .val (c_hi)
  );

  // Floor guarantees C[k] <= x < C[k+1] (for k<31), so both are non-negative;
  // 8 bits keeps them wrap-free regardless.
  assign diff_hi = {1'b0, c_hi} - {1'b0, x_q};
  assign diff_lo = {1'b0, x_q}  - {1'b0, c_lo};
`endif

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    code_d     = code_q;
    bit_d      = bit_q;
    code_out_d = code_out_q;
    valid_d    = 1'b0;
    rom_idx    = code_q;

    case (state_q)
      ST_IDLE: begin
        if (en && ready) begin
          x_d     = in;
          code_d  = '0;
          bit_d   = 3'd4;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        rom_idx = trial;
        if (c_lo <= x_q) begin
          code_d = trial;
        end
        bit_d = bit_q - 3'd1;
        if (bit_q == 3'd0) begin
`ifdef EXP_LOG_ENCODER_ROUND_EN
          state_d = ST_ROUND;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef EXP_LOG_ENCODER_ROUND_EN
      ST_ROUND: begin
        if ((code_q != '1) && (diff_hi < diff_lo)) begin
          code_d = code_inc;
        end
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        code_out_d = code_q;
        valid_d    = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Enable drop aborts any in-flight work without publishing a result.
    if ((state_q != ST_IDLE) && !en) begin
      state_d    = ST_IDLE;
      code_out_d = code_out_q;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      code_q     <= '0;
      bit_q      <= '0;
      code_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      code_q     <= code_d;
      bit_q      <= bit_d;
      code_out_q <= code_out_d;
      valid_q    <= valid_d;
    end
  end

  assign code_out = code_out_q;
  assign valid    = valid_q;
`ifdef EXP_LOG_ENCODER_ROUND_EN
  assign busy     = (state_q == ST_SEARCH) || (state_q == ST_ROUND);
`else
  assign busy     = (state_q == ST_SEARCH);
`endif

endmodule

// File: tb/tb_exp_log_encoder.sv
// tb_exp_log_encoder
//   Self-checking bench for exp_log_encoder: directed cases, curve round trip,
//   random amplitudes against a reference model, enable abort, mid-search
//   reset and start-while-busy / back-to-back starts.
module tb_exp_log_encoder;

`ifdef EXP_LOG_ENCODER_ROUND_EN
  localparam int LAT      = 7;
  localparam bit ROUND_ON = 1'b1;
`else
  localparam int LAT      = 6;
  localparam bit ROUND_ON = 1'b0;
`endif

  logic       clk;
  logic       nrst;
  logic       en;
  logic [6:0] in_s;
  logic       ready;
  logic [4:0] code_out;
  logic       valid;
  logic       busy;

  int n_vec;
  int n_err;
  int last_code;

  int curve [32] = '{0, 0, 0, 1, 2, 3, 4, 6, 8, 10, 13, 15, 19, 22, 25, 29,
                     33, 38, 42, 47, 52, 58, 63, 69, 76, 82, 89, 96, 103, 111, 118, 127};

  exp_log_encoder dut (
    .MHz10    (clk),
    .nrst     (nrst),
    .en       (en),
    .in       (in_s),
    .ready    (ready),
    .code_out (code_out),
    .valid    (valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic int ref_code(input int x);
    int k;
    int d_hi;
    int d_lo;
    k = 0;
    for (int i = 0; i < 32; i++) begin
      if (curve[i] <= x) k = i;
    end
    if (ROUND_ON && k < 31) begin
      d_hi = curve[k+1] - x;
      d_lo = x - curve[k];
      if (d_hi < d_lo) k = k + 1;
    end
    return k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after an edge; the next rising edge becomes E0.
  task automatic pulse_start(input int x);
    in_s  = 7'(x);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  // Called 1 time unit after E0; returns 1 time unit after the result edge.
  task automatic expect_result(input string tag, input int exp);
    for (int i = 0; i <= LAT; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      chk({tag, "_busy"}, 32'(busy), 32'(i < LAT - 1));
      chk({tag, "_valid"}, 32'(valid), 32'(i == LAT));
    end
    chk({tag, "_code"}, 32'(code_out), 32'(exp));
    last_code = exp;
  endtask

  task automatic run(input string tag, input int x);
    pulse_start(x);
    expect_result(tag, ref_code(x));
  endtask

  initial begin
    int x;
    n_vec     = 0;
    n_err     = 0;
    last_code = 0;
    nrst  = 1'b0;
    en    = 1'b0;
    ready = 1'b0;
    in_s  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_code", 32'(code_out), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b1;

    // Directed points, with spec values cross-checked against the model.
    pulse_start(127); expect_result("in127", 31);
    pulse_start(0);   expect_result("in0", 2);
    pulse_start(3);   expect_result("in3", 5);
    pulse_start(1);   expect_result("in1", 3);
    pulse_start(50);  expect_result("in50", ROUND_ON ? 20 : 19);
    pulse_start(60);  expect_result("in60", 21);
    pulse_start(100); expect_result("in100", ROUND_ON ? 28 : 27);

    for (int k = 3; k < 32; k++) begin
      pulse_start(curve[k]);
      expect_result($sformatf("rt%0d", k), k);
    end

    for (int n = 0; n < 40; n++) begin
      x = int'($urandom_range(0, 127));
      run($sformatf("rnd%0d_x%0d", n, x), x);
    end

    // Enable drop during the third SEARCH cycle.
    pulse_start(90);
    repeat (2) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < LAT; i++) begin
      chk("abort_valid", 32'(valid), 32'd0);
      chk("abort_code", 32'(code_out), 32'(last_code));
      @(posedge clk);
      #1;
    end
    en = 1'b1;

    // Asynchronous reset mid-search.
    pulse_start(127);
    @(posedge clk);
    #20;
    nrst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_code", 32'(code_out), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    last_code = 0;
    for (int i = 0; i < LAT + 1; i++) begin
      @(posedge clk);
      #1;
      chk("arst_novalid", 32'(valid), 32'd0);
    end

    // Start while busy is ignored; start during valid is accepted.
    pulse_start(127);
    @(posedge clk);
    #1;
    in_s  = 7'd10;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    for (int i = 3; i < LAT; i++) begin
      @(posedge clk);
      #1;
      chk("busy_ign_valid", 32'(valid), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("busy_ign_valid1", 32'(valid), 32'd1);
    chk("busy_ign_code", 32'(code_out), 32'd31);
    pulse_start(10);
    chk("b2b_valid_drop", 32'(valid), 32'd0);
    expect_result("b2b", 9);

    repeat (3) begin
      @(posedge clk);
      #1;
      chk("tail_valid", 32'(valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
